// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment
// patterns (g..a, active-high), scan FSM states and the BCD encoder.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_e;

    // Codes above 9 are not valid BCD and are shown dark rather than
    // as hex glyphs; the decimal point is carried through as bit 7.
    function automatic logic [7:0] seg_encode(input logic [3:0] bcd, input logic dp);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return {dp, seg};
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD + decimal point to {DP, g..a} segment pattern.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dp,
    output logic [7:0] seg
);

    // Pure lookup; the table lives in the package so the reset value
    // of the scan controller and the decoder can never disagree.
    always_comb begin
        seg = seg_encode(bcd, dp);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller. A shadow bank is written
// digit by digit and copied into the displayed (active) bank only at a
// frame boundary, so a multi-digit update never shows half-applied.
// All outputs are registered; the output flops are loaded from the
// next-state values so they always describe the cycle the FSM is in.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SHOW_CYC  = 50000,
    parameter int BLANK_CYC = 2000,
    parameter int CNT_W     = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_idx,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       wr_commit,
    output logic       wr_ready,
    input  logic [3:0] digit_en,
    output logic [7:0] seg_out,
    output logic [3:0] seg_sel,
    output logic       frame_start
);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [7:0]       SEG_RESET  = {1'b0, SEG_0};

    // Each bank entry is {dp, bcd}.
    scan_state_e              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               dig_q, dig_d;
    logic [NUM_DIGITS-1:0][4:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][4:0] active_q, active_d;
    logic                     pending_q, pending_d;
    logic                     wr_ready_q, wr_ready_d;
    logic [7:0]               seg_out_q, seg_out_d;
    logic [3:0]               seg_sel_q, seg_sel_d;
    logic                     frame_start_q, frame_start_d;

    logic                     slot_start;
    logic                     boundary;
    logic [3:0]               dec_bcd;
    logic                     dec_dp;
    logic [7:0]               dec_seg;

    // Scan sequencing: count out the SHOW and BLANK slots and advance the
    // digit pointer; a zero-length blank goes straight to the next digit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        dig_d      = dig_q;
        slot_start = 1'b0;
        case (state_q)
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    if (BLANK_CYC == 0) begin
                        dig_d      = dig_q + 2'd1;
                        slot_start = 1'b1;
                    end else begin
                        state_d = BLANK;
                    end
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d      = '0;
                    state_d    = SHOW;
                    dig_d      = dig_q + 2'd1;
                    slot_start = 1'b1;
                end
            end
            default: begin
                state_d = SHOW;
                cnt_d   = '0;
                dig_d   = 2'd0;
            end
        endcase
        boundary = slot_start && (dig_q == 2'd3);
    end

    // Shadow writes and the commit handshake. Writes are locked out while
    // a commit is pending so the bank being copied is frozen; the copy
    // itself only ever happens at the wrap from digit 3 back to digit 0.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (wr_en && !pending_q) begin
            shadow_d[wr_idx] = {wr_dp, wr_data};
        end
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (wr_commit && !pending_q) begin
            pending_d = 1'b1;
        end
    end

    assign dec_bcd = active_d[dig_d][3:0];
    assign dec_dp  = active_d[dig_d][4];

    seg_decoder u_decoder (
        .bcd (dec_bcd),
        .dp  (dec_dp),
        .seg (dec_seg)
    );

    // Output pattern for the upcoming cycle. The digit enable is captured
    // once when a digit slot opens and then held, so toggling it mid-slot
    // cannot chop a digit's on-time.
    always_comb begin
        seg_out_d     = 8'h00;
        seg_sel_d     = seg_sel_q;
        frame_start_d = boundary;
        wr_ready_d    = !pending_d;
        if (state_d == SHOW) begin
            seg_out_d = dec_seg;
            if (slot_start) begin
                seg_sel_d = digit_en[dig_d] ? (4'b0001 << dig_d) : 4'b0000;
            end
        end else begin
            seg_sel_d = 4'b0000;
        end
    end

    // Scan FSM, counter and digit pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            dig_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
        end
    end

    // Digit banks and commit flag; reset discards any staged update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    // Registered pin drivers; reset shows digit 0 holding zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out_q     <= SEG_RESET;
            seg_sel_q     <= 4'b0001;
            frame_start_q <= 1'b0;
            wr_ready_q    <= 1'b1;
        end else begin
            seg_out_q     <= seg_out_d;
            seg_sel_q     <= seg_sel_d;
            frame_start_q <= frame_start_d;
            wr_ready_q    <= wr_ready_d;
        end
    end

    assign seg_out     = seg_out_q;
    assign seg_sel     = seg_sel_q;
    assign frame_start = frame_start_q;
    assign wr_ready    = wr_ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short scan (4 show + 1 blank,
// 20-cycle frame). Expected patterns are hand-derived segment codes.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       wr_commit;
    logic       wr_ready;
    logic [3:0] digit_en;
    logic [7:0] seg_out;
    logic [3:0] seg_sel;
    logic       frame_start;

    int         compareCount;
    int         mismatchCount;
    int         k;
    logic [7:0] expPat [4];
    logic [3:0] expEn;
    logic       expReady;

    seg_scan_ctrl #(
        .SHOW_CYC  (4),
        .BLANK_CYC (1),
        .CNT_W     (17)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .wr_commit   (wr_commit),
        .wr_ready    (wr_ready),
        .digit_en    (digit_en),
        .seg_out     (seg_out),
        .seg_sel     (seg_sel),
        .frame_start (frame_start)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %02h, expected %02h", tag, observed, expected);
        end
    endtask

    // Drive the write-port inputs for the next clock edge.
    task automatic applyStimulus(input logic en, input logic [1:0] idx, input logic [3:0] data,
                                 input logic dp, input logic commit);
        wr_en     = en;
        wr_idx    = idx;
        wr_data   = data;
        wr_dp     = dp;
        wr_commit = commit;
    endtask

    // Expected outputs at cycle k after reset release: slot = k mod 20,
    // digit = slot / 5, the fifth cycle of each digit is the blank.
    task automatic checkFrame();
        int         p;
        int         d;
        bit         show;
        logic [3:0] sel;
        logic [7:0] pat;
        logic       fs;
        p    = k % 20;
        d    = p / 5;
        show = (p % 5) < 4;
        sel  = (show && expEn[d]) ? 4'(1 << d) : 4'b0000;
        pat  = show ? expPat[d] : 8'h00;
        fs   = (p == 0) && (k > 0);
        checkOutput($sformatf("seg_sel k=%0d", k), {4'b0, seg_sel}, {4'b0, sel});
        checkOutput($sformatf("seg_out k=%0d", k), seg_out, pat);
        checkOutput($sformatf("frame_start k=%0d", k), {7'b0, frame_start}, {7'b0, fs});
        checkOutput($sformatf("wr_ready k=%0d", k), {7'b0, wr_ready}, {7'b0, expReady});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        checkFrame();
    endtask

    task automatic runTo(input int target);
        while (k < target) step();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " seg_sel"}, {4'b0, seg_sel}, 8'h01);
        checkOutput({tag, " seg_out"}, seg_out, 8'h3F);
        checkOutput({tag, " wr_ready"}, {7'b0, wr_ready}, 8'h01);
        checkOutput({tag, " frame_start"}, {7'b0, frame_start}, 8'h00);
    endtask

    // Directed sequence: idle scan, commit, locked-out write, commit on
    // the boundary cycle, digit disable, and reset with a commit pending.
    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        k             = 0;
        rst           = 1'b1;
        digit_en      = 4'b1111;
        expEn         = 4'b1111;
        expReady      = 1'b1;
        for (int i = 0; i < 4; i++) expPat[i] = 8'h3F;
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;
        k   = 0;
        checkFrame();
        runTo(40);

        $display("[TB] write 1,2,3.,4 and commit");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, i[1:0], 4'(i + 1), (i == 2), 1'b0);
            step();
        end
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
        expReady = 1'b0;
        step();
        applyStimulus(1'b1, 2'd0, 4'd9, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        runTo(59);
        expPat   = '{8'h06, 8'h5B, 8'hCF, 8'h66};
        expReady = 1'b1;
        step();
        runTo(80);

        $display("[TB] commit on the boundary cycle");
        applyStimulus(1'b1, 2'd0, 4'd5, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        runTo(99);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
        expReady = 1'b0;
        step();
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        runTo(119);
        expPat[0] = 8'h6D;
        expReady  = 1'b1;
        step();

        $display("[TB] digit 2 disabled");
        digit_en = 4'b1011;
        expEn    = 4'b1011;
        runTo(140);
        digit_en = 4'b1111;
        expEn    = 4'b1111;

        $display("[TB] reset during digit 1 blank with commit pending");
        applyStimulus(1'b1, 2'd3, 4'd7, 1'b0, 1'b1);
        expReady = 1'b0;
        step();
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        runTo(149);
        rst = 1'b1;
        #1;
        checkResetState("mid-frame reset");
        @(posedge clk);
        #1;
        checkResetState("mid-frame reset held");
        rst      = 1'b0;
        k        = 0;
        expReady = 1'b1;
        for (int i = 0; i < 4; i++) expPat[i] = 8'h3F;
        checkFrame();
        runTo(20);

        $display("[TB] write with commit in the same cycle");
        applyStimulus(1'b1, 2'd1, 4'd8, 1'b1, 1'b1);
        expReady = 1'b0;
        step();
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        runTo(39);
        expPat[1] = 8'hFF;
        expReady  = 1'b1;
        step();
        runTo(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scheduler that shares one 8-bit seven-segment bus across four digit positions. Holds a shadow and an active copy of four BCD digits plus decimal points, and commits shadow to active atomically at frame boundaries so a counter update never tears across digits. Sits between the BCD counter logic and the board's `seg_out`/`seg_sel` pins. Replaces the fixed `seg_sel = 4'b0001` single-digit drive.

## Interface
Parameters:
- `SHOW_CYC`, default 50000: clock cycles each digit is driven (≥1).
- `BLANK_CYC`, default 2000: all-off cycles after each digit, to prevent ghosting (≥0).
- `CNT_W`, default 17: slot counter width; must hold max(SHOW_CYC, BLANK_CYC)−1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-high.
- `wr_en` in 1: write one shadow digit; accepted only when `wr_ready`=1.
- `wr_idx` in 2: digit position to write (0 = `seg_sel[0]`).
- `wr_data` in 4: BCD value.
- `wr_dp` in 1: decimal point for that digit.
- `wr_commit` in 1: request copy of shadow to active at the next frame boundary.
- `wr_ready` out 1: `!pending`.
- `digit_en` in 4: per-position enable; a disabled position keeps its slot but drives `seg_sel` = 0.
- `seg_out` out 8: {DP, g..a}, active-high.
- `seg_sel` out 4: one-hot digit select, active-high.
- `frame_start` out 1: one-cycle pulse on the first SHOW cycle of digit 0.

## Operation
- FSM states: SHOW and BLANK. Slot counter `cnt` and digit pointer `dig` (0..3).
- SHOW: drive `seg_sel` = `1<<dig` (or 0 if `!digit_en[dig]`), and `seg_out` = encode(active[dig]).
  - Stay for SHOW_CYC cycles.
  - Then go to BLANK, or directly to the next digit's SHOW if BLANK_CYC = 0.
- BLANK: `seg_sel` = 0 and `seg_out` = 0 for BLANK_CYC cycles. Then `dig` ← `dig`+1 mod 4 and return to SHOW.
- Frame boundary: the transition out of digit 3's last slot cycle, into digit 0 SHOW.
  - If `pending`: active ← shadow for all four digits and DPs, then clear `pending`.
- Encoding (g..a):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - Codes 10–15 = 0000000 (blank). DP is appended as bit 7.
- Writes:
  - `wr_en & wr_ready`: shadow[wr_idx] ← {wr_dp, wr_data}.
  - `wr_en` while `!wr_ready`: ignored.
- Commit: `wr_commit & !pending` sets `pending`. `wr_commit` while pending is ignored.
- Simultaneous `wr_en` and `wr_commit` in one cycle (ready=1): the write lands and is included in the commit.
- `wr_commit` asserted on the boundary cycle itself: `pending` sets, and the copy happens at the following boundary.

## Timing
- All outputs are registered.
- Reset values:
  - State SHOW, `dig` = 0, `cnt` = 0.
  - Shadow and active all 0 with DP 0. `pending` = 0.
  - `wr_ready` = 1, `seg_sel` = 4'b0001 (digit_en ignored during reset), `seg_out` = 8'h3F, `frame_start` = 0.
- First cycle after reset release: outputs show digit 0 from active (0). That cycle counts as SHOW cycle 1. `frame_start` is not pulsed for the post-reset frame.
- Frame length = 4 × (SHOW_CYC + BLANK_CYC) cycles.
- Commit latency: new values are visible on the first digit-0 SHOW cycle after the boundary. `wr_ready` rises in that same cycle.
- `digit_en` is sampled at each slot start and held for the slot.
- Reset asserted mid-frame: immediate return to reset values. Any pending commit and shadow contents are discarded.

## Structure
- Package `seg_pkg` holds:
  - the ten segment constants and `SEG_BLANK`;
  - the state enum {SHOW, BLANK};
  - the pure function `seg_encode(bcd, dp)`.
- One sub-module `seg_decoder`: combinational 4-bit BCD + DP to 8-bit pattern, using `seg_pkg`.
- Counter, FSM, shadow/active banks and the handshake stay in `seg_scan_ctrl`.

## Test plan
Bench parameters: SHOW_CYC = 4, BLANK_CYC = 1.
- Reset release → `seg_sel` sequence 0001×4, 0000×1, 0010×4, 0000×1, 0100×4, 0000×1, 1000×4, 0000×1, repeating; `seg_out` = 8'h3F during every SHOW.
- Write shadow {1,2,3,4} with DP on digit 2, then commit → `wr_ready` = 0 until the boundary; next frame shows 06, 5B, CF, 66 (hex); `wr_ready` = 1 and `frame_start` = 1 on the first 06 cycle.
- `wr_en` to digit 0 value 9 while pending → ignored; digit 0 still shows the committed value, not 6F.
- `wr_commit` exactly on the boundary cycle → current frame unchanged; update appears one frame later.
- `digit_en` = 4'b1011 → slot for digit 2 drives `seg_sel` = 0000 for 4 cycles; frame length stays 20 cycles.
- Reset asserted mid-BLANK of digit 1 with a commit pending → `seg_sel` = 0001 and `seg_out` = 3F next cycle; pending cleared; shadow reads back zeros.
